// File: rtl/mant_mul_seq.sv
// Sequential 24x24 unsigned mantissa multiplier: one shift-and-add step per cycle through a
// shared 25-bit adder, with valid/ready handshakes and a zero-operand early-out.

module add_25bits (
  input  logic [24:0] i_data_one,
  input  logic [24:0] i_data_two,
  input  logic        i_carry,
  output logic [24:0] o_sum,
  output logic        o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_data_one} + {1'b0, i_data_two} + {25'd0, i_carry};

endmodule

module mant_mul_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [23:0] i_mant_a,
  input  logic [23:0] i_mant_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [47:0] o_product,
  output logic        o_busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [23:0] mcand_q;
  logic [23:0] acc_q;
  logic [23:0] mq_q;
  logic [4:0]  cnt_q;
  logic        valid_q;
  logic        busy_q;

  logic [24:0] sum;
  logic [24:0] addend;
  logic        unused_carry;

  assign addend = mq_q[0] ? {1'b0, mcand_q} : 25'd0;

  // acc + mcand < 2^25, so the carry-out can never be set.
  add_25bits u_add (
    .i_data_one ({1'b0, acc_q}),
    .i_data_two (addend),
    .i_carry    (1'b0),
    .o_sum      (sum),
    .o_carry    (unused_carry)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      mcand_q <= 24'd0;
      acc_q   <= 24'd0;
      mq_q    <= 24'd0;
      cnt_q   <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            mcand_q <= i_mant_a;
            acc_q   <= 24'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            if ((i_mant_a == 24'd0) || (i_mant_b == 24'd0)) begin
              mq_q    <= 24'd0;
              valid_q <= 1'b1;
              state_q <= StDone;
            end else begin
              mq_q    <= i_mant_b;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          acc_q <= sum[24:1];
          mq_q  <= {sum[0], mq_q[23:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_ready   = (state_q == StIdle) & ~i_rst;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_product = {acc_q, mq_q};

endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed bench for mant_mul_seq: latency, products, early-out, backpressure, reset abort and
// back-to-back handshakes against hand-computed values.

module tb_mant_mul_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic        out_valid;
  logic        in_ready;
  logic [47:0] product;
  logic        busy;

  int tests;
  int fails;
  logic carry_seen;

  mant_mul_seq dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (in_valid),
    .o_ready   (out_ready),
    .i_mant_a  (mant_a),
    .i_mant_b  (mant_b),
    .o_valid   (out_valid),
    .i_ready   (in_ready),
    .o_product (product),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dut.u_add.o_carry === 1'b1) carry_seen = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single edge; the caller makes sure o_ready is high.
  task automatic accept(input logic [23:0] a, input logic [23:0] b);
    in_valid = 1'b1;
    mant_a   = a;
    mant_b   = b;
    step();
    in_valid = 1'b0;
  endtask

  // Edges after acceptance until o_valid is seen; 40 means the bound expired.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if (out_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 48'd0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b valid=%b busy=%b product=%h, want 0 0 0 0",
               out_ready, out_valid, busy, product);
    end
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (out_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b, want 1", out_ready);
    end
  endtask

  task automatic test_unit();
    int lat;
    in_ready = 1'b1;
    accept(24'h800000, 24'h800000);
    wait_valid(lat);
    tests++;
    if (lat !== 24) begin
      fails++;
      $display("FAIL unit_latency: got %0d, want 24", lat);
    end
    tests++;
    if (product !== 48'h400000000000 || busy !== 1'b1 || out_ready !== 1'b0) begin
      fails++;
      $display("FAIL unit_product: got %h busy=%b ready=%b, want 400000000000 1 0",
               product, busy, out_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || out_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL unit_return_idle: valid=%b ready=%b busy=%b, want 0 1 0",
               out_valid, out_ready, busy);
    end
  endtask

  task automatic test_max();
    int lat;
    in_ready   = 1'b1;
    carry_seen = 1'b0;
    accept(24'hFFFFFF, 24'hFFFFFF);
    wait_valid(lat);
    tests++;
    if (lat !== 24 || product !== 48'hFFFFFE000001) begin
      fails++;
      $display("FAIL max_product: lat=%0d product=%h, want 24 fffffe000001", lat, product);
    end
    tests++;
    if (carry_seen !== 1'b0) begin
      fails++;
      $display("FAIL max_carry_out: got %b, want 0", carry_seen);
    end
    step();
  endtask

  task automatic test_zero();
    int lat;
    in_ready = 1'b1;
    accept(24'h000000, 24'hC00000);
    wait_valid(lat);
    tests++;
    if (lat !== 0 || product !== 48'd0) begin
      fails++;
      $display("FAIL zero_a: lat=%0d product=%h, want 0 0", lat, product);
    end
    step();
    tests++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_a_idle: ready=%b valid=%b, want 1 0", out_ready, out_valid);
    end
    accept(24'hC00000, 24'h000000);
    wait_valid(lat);
    tests++;
    if (lat !== 0 || product !== 48'd0) begin
      fails++;
      $display("FAIL zero_b: lat=%0d product=%h, want 0 0", lat, product);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    in_ready = 1'b0;
    accept(24'hC00000, 24'hA00000);
    wait_valid(lat);
    tests++;
    if (lat !== 24) begin
      fails++;
      $display("FAIL bp_latency: got %0d, want 24", lat);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      mant_a   = 24'h123456 + 24'(i);
      mant_b   = 24'h654321;
      step();
      tests++;
      if (out_valid !== 1'b1 || out_ready !== 1'b0 || product !== 48'h780000000000) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b product=%h, want 1 0 780000000000",
                 i, out_valid, out_ready, product);
      end
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: valid=%b ready=%b, want 0 1", out_valid, out_ready);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    in_ready = 1'b1;
    accept(24'hFFFFFF, 24'hFFFFFF);
    for (int i = 0; i < 12; i++) step();
    rst = 1'b1;
    #1;
    tests++;
    if (out_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 48'd0) begin
      fails++;
      $display("FAIL midop_reset: ready=%b valid=%b busy=%b product=%h, want 0 0 0 0",
               out_ready, out_valid, busy, product);
    end
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (out_ready !== 1'b1) begin
      fails++;
      $display("FAIL midop_release_ready: got %b, want 1", out_ready);
    end
    accept(24'h900000, 24'h880000);
    wait_valid(lat);
    tests++;
    if (lat !== 24 || product !== 48'h4C8000000000) begin
      fails++;
      $display("FAIL midop_next_product: lat=%0d product=%h, want 24 4c8000000000",
               lat, product);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    in_ready = 1'b1;
    in_valid = 1'b1;
    mant_a   = 24'hFFFFFF;
    mant_b   = 24'h800000;
    step();
    // Operands change right after acceptance; the first result must not see them.
    mant_a = 24'hA00000;
    mant_b = 24'hA00000;
    wait_valid(lat);
    tests++;
    if (lat !== 24 || product !== 48'h7FFFFF800000) begin
      fails++;
      $display("FAIL b2b_first: lat=%0d product=%h, want 24 7fffff800000", lat, product);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_handshake: valid=%b ready=%b, want 0 1", out_valid, out_ready);
    end
    step();
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || out_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second_accept: busy=%b ready=%b, want 1 0", busy, out_ready);
    end
    wait_valid(lat);
    tests++;
    if (lat !== 24 || product !== 48'h640000000000) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d product=%h, want 24 640000000000", lat, product);
    end
    step();
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    carry_seen = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_ready   = 1'b0;
    mant_a     = 24'd0;
    mant_b     = 24'd0;
    test_reset();
    test_unit();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
